// File: rtl/bist_controller.sv
// BIST sequencer: clears the MISR, runs the TPG for PATTERN_COUNT cycles, then captures and grades the signature.
// Define BIST_FAIL_COUNT_EN to build the saturating mismatch counter behind fail_count.
module bist_controller #(
  parameter int                   PATTERN_COUNT = 15,
  parameter int                   CNT_WIDTH     = 4,
  parameter int                   SIG_WIDTH     = 4,
  parameter logic [0:SIG_WIDTH-1] GOLDEN_SIG    = 4'b1011
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [0:SIG_WIDTH-1] misr_sig,
  output logic                 bist_mode,
  output logic                 tpg_enable,
  output logic                 misr_clear,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [0:SIG_WIDTH-1] signature_out,
  output logic [7:0]           fail_count
);

  if (PATTERN_COUNT < 1 || PATTERN_COUNT > (2 ** CNT_WIDTH) - 1) begin : g_bad_pattern_count
    $error("bist_controller: PATTERN_COUNT out of range for CNT_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(PATTERN_COUNT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] count;
  logic                 in_test;
  logic                 aborting;
  logic                 sig_match;

  assign in_test   = (state == S_CLEAR) || (state == S_RUN) ||
                     (state == S_SETTLE) || (state == S_CAPTURE);
  assign aborting  = in_test && abort;
  assign sig_match = (misr_sig == GOLDEN_SIG);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_RUN;
      S_RUN:     if (count == LAST_COUNT) state_nxt = S_SETTLE;
      S_SETTLE:  state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_DONE;
      // Leaving DONE needs start low, so a held start cannot retrigger.
      S_DONE:    if (!start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (aborting) state_nxt = S_IDLE;
  end

  always_comb begin
    bist_mode  = in_test;
    busy       = in_test;
    tpg_enable = (state == S_RUN);
    misr_clear = (state == S_CLEAR);
    done       = (state == S_DONE);
  end

  // Counter holds at LAST_COUNT on the RUN exit edge so it never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state == S_CLEAR) begin
      count <= '0;
    end else if (state == S_RUN && state_nxt == S_RUN) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass          <= 1'b0;
      fail          <= 1'b0;
      signature_out <= '0;
    end else if (aborting || state_nxt == S_CLEAR) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (state == S_CAPTURE) begin
      signature_out <= misr_sig;
      pass          <= sig_match;
      fail          <= !sig_match;
    end
  end

`ifdef BIST_FAIL_COUNT_EN
  logic [7:0] fail_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail_cnt <= 8'd0;
    end else if (state == S_CAPTURE && !abort && !sig_match && fail_cnt != 8'hFF) begin
      fail_cnt <= fail_cnt + 8'd1;
    end
  end

  assign fail_count = fail_cnt;
`else
  assign fail_count = 8'd0;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Directed and randomized bench for bist_controller against a run-level behavioural model.
module tb_bist_controller;
  localparam int         PC   = 15;
  localparam logic [0:3] GOLD = 4'b1011;

  logic       clock = 1'b0;
  logic       reset, start, abort;
  logic [0:3] misr_sig;
  logic       bist_mode, tpg_enable, misr_clear, busy, done, pass, fail;
  logic [0:3] signature_out;
  logic [7:0] fail_count;

  int         errors = 0;
  int         checks = 0;
  logic [0:3] exp_sig_out;
  int         exp_fail_count;

  bist_controller dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .misr_sig(misr_sig),
    .bist_mode(bist_mode), .tpg_enable(tpg_enable), .misr_clear(misr_clear), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .signature_out(signature_out), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_fc();
`ifdef BIST_FAIL_COUNT_EN
    return exp_fail_count;
`else
    return 0;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_bist_mode"}, 32'(bist_mode), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_tpg"}, 32'(tpg_enable), 0);
    check({tag, "_clr"}, 32'(misr_clear), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_fail"}, 32'(fail), 0);
    check({tag, "_sig"}, 32'(signature_out), 0);
    check({tag, "_fcnt"}, 32'(fail_count), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_bist_mode"}, 32'(bist_mode), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_tpg"}, 32'(tpg_enable), 0);
    check({tag, "_clr"}, 32'(misr_clear), 0);
  endtask

  // One run from IDLE; abort_at>0 aborts during that RUN cycle (1-based).
  task automatic do_run(input logic [0:3] sig, input int abort_at, input bit hold_start);
    int edge_n, clears, tpg, tpg_last;
    bit gap;
    start = 1'b1;
    tick;
    edge_n = 0;
    if (!hold_start) start = 1'b0;
    check("clear_pass", 32'(pass), 0);
    check("clear_fail", 32'(fail), 0);
    check("clear_sig_kept", 32'(signature_out), 32'(exp_sig_out));
    check("clear_busy", 32'(busy), 1);
    clears = 0; tpg = 0; tpg_last = -1; gap = 0;
    while (!done && edge_n < PC + 10) begin
      if (misr_clear) clears++;
      if (tpg_enable) begin
        if (tpg_last >= 0 && tpg_last != edge_n - 1) gap = 1;
        tpg_last = edge_n;
        tpg++;
      end
      if (abort_at > 0 && tpg == abort_at && tpg_enable) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_tpg", 32'(tpg_enable), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_pass", 32'(pass), 0);
        check("abort_fail", 32'(fail), 0);
        check("abort_sig", 32'(signature_out), 32'(exp_sig_out));
        check("abort_fcnt", 32'(fail_count), 32'(exp_fc()));
        start = 1'b0;
        return;
      end
      misr_sig = (tpg >= PC) ? sig : 4'($urandom);
      tick;
      edge_n++;
    end
    check("done_seen", 32'(done), 1);
    check("done_edge", 32'(edge_n), PC + 3);
    check("clear_cycles", 32'(clears), 1);
    check("tpg_cycles", 32'(tpg), PC);
    check("tpg_contig", 32'(gap), 0);
    exp_sig_out = sig;
    if (sig != GOLD && exp_fail_count < 255) exp_fail_count++;
    check("res_pass", 32'(pass), 32'(sig == GOLD));
    check("res_fail", 32'(fail), 32'(sig != GOLD));
    check("res_sig", 32'(signature_out), 32'(sig));
    check("res_fcnt", 32'(fail_count), 32'(exp_fc()));
    if (hold_start) begin
      for (int i = 0; i < 10; i++) begin
        tick;
        check("hold_done", 32'(done), 1);
        check("hold_busy", 32'(busy), 0);
      end
      start = 1'b0;
    end
    tick;
    check_idle("post_run");
    check("held_pass", 32'(pass), 32'(sig == GOLD));
    check("held_sig", 32'(signature_out), 32'(sig));
  endtask

  initial begin
    logic [0:3] rsig;
    int         rab;
    reset = 1'b1; start = 1'b0; abort = 1'b0; misr_sig = 4'b0000;
    exp_sig_out = 4'b0000; exp_fail_count = 0;
    #1;
    check_all_zero("reset0");
    tick; tick;
    reset = 1'b0;
    tick;
    check_idle("after_reset");

    do_run(GOLD, 0, 1'b0);
    do_run(4'b0110, 0, 1'b0);
    do_run(GOLD, 5, 1'b0);
    do_run(GOLD, 0, 1'b1);
    do_run(4'b0110, 0, 1'b0);

    // Reset asserted in RUN cycle 7 must clear outputs without a clock edge.
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    check("rst_mid_tpg_before", 32'(tpg_enable), 1);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    exp_sig_out = 4'b0000;
    exp_fail_count = 0;
    tick;
    reset = 1'b0;
    tick;
    check_idle("rst_mid_after");
    do_run(GOLD, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      rsig = ($urandom_range(0, 2) == 0) ? GOLD : 4'($urandom);
      rab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PC)) : 0;
      do_run(rsig, rab, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequencing and signature-check stage downstream of the 4-bit, 2-input MISR in the BIST datapath.
- On `start`, it does the following in order:
  - clears the MISR;
  - enables the test pattern generator for a fixed number of clock cycles;
  - waits one cycle for the final MISR update;
  - captures the MISR signature and compares it against a golden value.
- Reports `done` with `pass` or `fail` to the system-level test controller.

Parameters:
- PATTERN_COUNT, 15: number of clock cycles `tpg_enable` is held high per run. Legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 4: width of the internal pattern counter.
- SIG_WIDTH, 4: signature width. Must equal the MISR width.
- GOLDEN_SIG, 4'b1011: expected fault-free signature. Bit i corresponds to MISR `dataOut[i]`.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request. Level-sampled in IDLE and DONE.
- abort  input  1  cancels a run in progress. Sampled in CLEAR, RUN, SETTLE and CAPTURE.
- misr_sig  input  [0:SIG_WIDTH-1]  MISR `dataOut`. Bit ordering matches the MISR.
- bist_mode  output  1  high in every state except IDLE and DONE. Selects TPG data into the circuit under test (CUT).
- tpg_enable  output  1  pattern generator advance enable.
- misr_clear  output  1  one-cycle synchronous clear request to the MISR.
- busy  output  1  identical to `bist_mode`.
- done  output  1  high while in DONE.
- pass  output  1  registered compare result, signature matched.
- fail  output  1  registered compare result, signature mismatched.
- signature_out  output  [0:SIG_WIDTH-1]  captured signature.
- fail_count  output  8  see Optional Feature.

Behaviour:
- Reset is asynchronous and active-high; `clock` is the block clock. Reset forces:
  - state to IDLE;
  - counter to 0;
  - all outputs to 0, including `signature_out` and `fail_count`.
- FSM, Moore:
  - IDLE: `start`=1 → CLEAR.
  - CLEAR: `misr_clear`=1, counter loaded with 0; next state RUN.
  - RUN: `tpg_enable`=1, counter increments each cycle. When counter==PATTERN_COUNT-1 → SETTLE. `tpg_enable` is therefore high exactly PATTERN_COUNT cycles.
  - SETTLE: `tpg_enable`=0, one cycle for the MISR to absorb the last response; next state CAPTURE.
  - CAPTURE: at the exiting edge, latch `misr_sig` into `signature_out`, and set `pass`=(`misr_sig`==GOLDEN_SIG) and `fail`=!`pass`; next state DONE.
  - DONE: `done`=1. Stays in DONE while `start`=1; `start`=0 → IDLE.
- `bist_mode`, `busy`, `tpg_enable`, `misr_clear` and `done` are decoded from the state register only, with no input-to-output combinational path.
- Latency: with `start` sampled at edge 0, the sequence is:
  - CLEAR in cycle 1;
  - RUN for cycles 2..PATTERN_COUNT+1;
  - SETTLE, then CAPTURE;
  - `done` rises after edge PATTERN_COUNT+3.
- Run results:
  - `pass`, `fail` and `signature_out` hold their values through DONE and IDLE until the next CLEAR.
  - Entering CLEAR clears `pass` and `fail` to 0; `signature_out` is retained.
  - `pass` and `fail` are never both 1.
- Abort:
  - `abort`=1 in CLEAR, RUN, SETTLE or CAPTURE → IDLE at the next edge.
  - Abort sets `pass`=`fail`=0, does not assert `done`, and does not update `signature_out`.
  - Abort takes priority over any other transition in the same cycle.
- `start` in any state other than IDLE or DONE is ignored.
- An asserted `start` held across DONE→IDLE does not retrigger a run: `start` must be sampled low in DONE before leaving.
- Reset asserted mid-run forces outputs low asynchronously, without waiting for a clock edge.
- The counter never wraps during a legal run. A PATTERN_COUNT outside the legal range is a configuration error and is flagged by a synthesis-time check.

Optional Feature:
- Macro: BIST_FAIL_COUNT_EN.
- Defined: `fail_count` is an 8-bit register that increments by 1 on each CAPTURE with a mismatch and saturates at 255. It is cleared only by reset; abort does not change it.
- Not defined: no counter logic is built and `fail_count` is tied to 8'd0.

Test Plan:
- Reset: assert reset with no clock edge → all outputs 0 immediately; after release the FSM is idle, with `busy`=0.
- Good run: defaults, one-cycle `start` pulse, `misr_sig`=4'b1011 from SETTLE onward →
  - `misr_clear` high exactly 1 cycle;
  - `tpg_enable` high exactly 15 consecutive cycles;
  - `done`=1 after edge 18, with `pass`=1, `fail`=0, `signature_out`=1011.
- Bad run: `misr_sig`=4'b0110 → `done`=1, `pass`=0, `fail`=1, `signature_out`=0110. With BIST_FAIL_COUNT_EN, `fail_count`=1.
- Abort: `abort` pulsed in the 5th RUN cycle → `tpg_enable` low on the next cycle, FSM idle, `done`/`pass`/`fail`=0, `signature_out` unchanged.
- Handshake: hold `start` high through DONE for 10 cycles → `done` stays 1 and no rerun occurs. Drop `start` → idle next edge. Pulse `start` again → `pass`/`fail` cleared during CLEAR and a full second run completes.
- Reset mid-run: assert reset at RUN cycle 7 → all outputs 0 asynchronously, no `done`. After release, a full run gives the correct result.
